br_hazard_ctrl: RTL and testbench

- Control-hazard controller in the ID stage, directly downstream of the branch-instruction detector. It consumes the detector's flag for JAL/JALR/B-type/AUIPC.
- On a flagged instruction it freezes fetch and squashes wrong-path instructions until EX resolves the branch. It then issues a one-cycle PC redirect to the correct address.
- Also keeps a saturating stall-cycle performance counter and raises a sticky timeout error if resolution never arrives.

---
 rtl/br_hazard_if.sv | 27 ++
 rtl/br_hazard_ctrl.sv | 79 +++++++
 tb/tb_br_hazard_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/br_hazard_if.sv
// br_hazard_if: ID-stage branch hazard bundle between the pipeline (master) and the hazard controller (slave).
interface br_hazard_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             br_detect;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic             ex_resolve_valid;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;
  logic             ext_flush;
  logic             pc_hold;
  logic             ifid_flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_err;
  modport master (
    output br_detect, id_valid, id_pc, ex_resolve_valid, ex_taken, ex_target, ext_flush,
    input  pc_hold, ifid_flush, redirect_valid, redirect_pc, stall_cnt, timeout_err
  );
  modport slave (
    input  br_detect, id_valid, id_pc, ex_resolve_valid, ex_taken, ex_target, ext_flush,
    output pc_hold, ifid_flush, redirect_valid, redirect_pc, stall_cnt, timeout_err
  );
endinterface

// File: rtl/br_hazard_ctrl.sv
// br_hazard_ctrl: freezes fetch and squashes IF/ID while a branch is unresolved, then redirects the PC once.
module br_hazard_ctrl #(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input logic       clk,
  input logic       rst,
  br_hazard_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;
  state_t           state_q, state_d;
  logic [XLEN-1:0]  fall_q, fall_d, rpc_q, rpc_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             terr_q, terr_d, hold, flush, detect;
  assign detect = bus.id_valid & bus.br_detect;
  always_comb begin
    state_d = state_q;
    fall_d  = fall_q;
    rpc_d   = rpc_q;
    wcnt_d  = wcnt_q;
    terr_d  = terr_q;
    hold    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: if (detect) begin
        hold    = 1'b1;
        flush   = 1'b1;
        fall_d  = bus.id_pc + XLEN'(4);
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        hold   = 1'b1;
        flush  = 1'b1;
        wcnt_d = wcnt_q + WW'(1);
        // a resolve arriving in the last allowed cycle beats the timeout
        if (bus.ex_resolve_valid) begin
          rpc_d   = bus.ex_taken ? bus.ex_target : fall_q;
          state_d = REDIR;
        end else if (wcnt_q == WW'(MAX_WAIT - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        flush   = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (bus.ext_flush) state_d = IDLE;
    stall_d = (hold && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fall_q  <= '0;
      rpc_q   <= '0;
      wcnt_q  <= '0;
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fall_q  <= fall_d;
      rpc_q   <= rpc_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      terr_q  <= terr_d;
    end
  end
  assign bus.pc_hold        = hold;
  assign bus.ifid_flush     = flush;
  assign bus.redirect_valid = (state_q == REDIR);
  assign bus.redirect_pc    = rpc_q;
  assign bus.stall_cnt      = stall_q;
  assign bus.timeout_err    = terr_q;
endmodule

// File: tb/tb_br_hazard_ctrl.sv
// tb_br_hazard_ctrl: directed table, hand-written corner sequences and random traffic against a reference model.
module tb_br_hazard_ctrl;
  localparam int MW = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  br_hazard_if #(.XLEN(32), .CNT_W(16)) b();
  br_hazard_if #(.XLEN(32), .CNT_W(4))  b4();
  assign b4.br_detect        = b.br_detect;
  assign b4.id_valid         = b.id_valid;
  assign b4.id_pc            = b.id_pc;
  assign b4.ex_resolve_valid = b.ex_resolve_valid;
  assign b4.ex_taken         = b.ex_taken;
  assign b4.ex_target        = b.ex_target;
  assign b4.ext_flush        = b.ext_flush;
  br_hazard_ctrl #(.XLEN(32), .CNT_W(16), .MAX_WAIT(MW)) dut  (.clk(clk), .rst(rst), .bus(b));
  br_hazard_ctrl #(.XLEN(32), .CNT_W(4),  .MAX_WAIT(MW)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  typedef struct {
    bit rst, det, idv; logic [31:0] pc; bit rv, tk; logic [31:0] tgt; bit xf;
    bit chk, e_hold, e_flush, e_rv; logic [31:0] e_rpc; int e_stall; bit e_terr;
  } vec_t;
  int n_vec = 0, n_err = 0;
  bit m_ok = 0, m_pend = 0, m_redir = 0, m_terr = 0;
  int m_age = 0, m_stall = 0;
  logic [31:0] m_fall = 0, m_rpc = 0;
  vec_t tbl[16];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic vec_t V(bit r, bit d, bit iv, logic [31:0] pc, bit rv, bit tk, logic [31:0] tgt, bit xf);
    vec_t v;
    v = '{r, d, iv, pc, rv, tk, tgt, xf, 0, 0, 0, 0, 32'h0, 0, 0};
    return v;
  endfunction
  function automatic int sat(int x, int m);
    return x > m ? m : x;
  endfunction
  task automatic model(vec_t v);
    bit nr;
    if (v.rst) begin
      m_ok = 1; m_pend = 0; m_redir = 0; m_terr = 0; m_age = 0; m_stall = 0; m_fall = 0; m_rpc = 0;
      return;
    end
    nr = m_pend && v.rv && !v.xf;
    if (m_pend) begin
      if (v.rv) begin
        m_rpc = v.tk ? v.tgt : m_fall;
        m_pend = 0;
      end else if (m_age == MW - 1) begin
        m_terr = 1;
        m_pend = 0;
      end else m_age++;
    end else if (!m_redir && v.det && v.idv) begin
      m_pend = 1; m_age = 0; m_fall = v.pc + 32'd4;
    end
    if (v.xf) m_pend = 0;
    m_redir = nr;
  endtask
  task automatic step(vec_t v, bit use_tbl);
    bit mh;
    rst = v.rst; b.br_detect = v.det; b.id_valid = v.idv; b.id_pc = v.pc;
    b.ex_resolve_valid = v.rv; b.ex_taken = v.tk; b.ex_target = v.tgt; b.ext_flush = v.xf;
    #1;
    mh = m_pend || (!m_redir && v.idv && v.det);
    if (use_tbl) begin
      if (v.chk) begin
        chk("tbl_hold", b.pc_hold, v.e_hold);
        chk("tbl_flush", b.ifid_flush, v.e_flush);
        chk("tbl_rv", b.redirect_valid, v.e_rv);
        if (v.e_rv) chk("tbl_rpc", b.redirect_pc, v.e_rpc);
        chk("tbl_stall", b.stall_cnt, v.e_stall);
        chk("tbl_terr", b.timeout_err, v.e_terr);
      end
    end else if (m_ok) begin
      chk("hold", b.pc_hold, mh);
      chk("flush", b.ifid_flush, mh || m_redir);
      chk("rv", b.redirect_valid, m_redir);
      if (m_redir) chk("rpc", b.redirect_pc, m_rpc);
      chk("stall", b.stall_cnt, sat(m_stall, 65535));
      chk("terr", b.timeout_err, m_terr);
    end
    if (m_ok) chk("stall4", b4.stall_cnt, sat(m_stall, 15));
    @(posedge clk);
    if (mh && !v.rst) m_stall++;
    model(v);
    @(negedge clk);
  endtask
  task automatic nop(int n);
    for (int i = 0; i < n; i++) step(V(0, 0, 0, 0, 0, 0, 0, 0), 0);
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
    tbl[1]  = '{1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
    tbl[2]  = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 0};
    tbl[3]  = '{0, 1, 1, 32'h100, 0, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 0, 0};
    tbl[4]  = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 1, 0};
    tbl[5]  = '{0, 0, 0, 32'h0, 1, 1, 32'h200, 0, 1, 1, 1, 0, 32'h0, 2, 0};
    tbl[6]  = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'h200, 3, 0};
    tbl[7]  = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 3, 0};
    tbl[8]  = '{0, 1, 1, 32'h1FC, 0, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 3, 0};
    tbl[9]  = '{0, 0, 0, 32'h0, 1, 0, 32'h400, 0, 1, 1, 1, 0, 32'h0, 4, 0};
    tbl[10] = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'h200, 5, 0};
    tbl[11] = '{0, 1, 1, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 5, 0};
    tbl[12] = '{0, 0, 0, 32'h0, 1, 0, 32'h400, 0, 1, 1, 1, 0, 32'h0, 6, 0};
    tbl[13] = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 1, 1, 32'h0, 7, 0};
    tbl[14] = '{0, 0, 0, 32'h0, 1, 1, 32'h900, 0, 1, 0, 0, 0, 32'h0, 7, 0};
    tbl[15] = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 7, 0};
    for (int i = 0; i < 16; i++) step(tbl[i], 1);
    // timeout: detect plus MAX_WAIT unresolved cycles, then sticky error
    step(V(1, 0, 0, 0, 0, 0, 0, 0), 0);
    step(V(0, 1, 1, 32'h40, 0, 0, 0, 0), 0);
    nop(MW);
    chk("to_terr", b.timeout_err, 1);
    chk("to_rv", b.redirect_valid, 0);
    chk("to_hold", b.pc_hold, 0);
    chk("to_stall", b.stall_cnt, 9);
    nop(3);
    chk("to_sticky", b.timeout_err, 1);
    // resolve in the last WAIT cycle wins over the timeout
    step(V(1, 0, 0, 0, 0, 0, 0, 0), 0);
    step(V(0, 1, 1, 32'h40, 0, 0, 0, 0), 0);
    nop(MW - 1);
    step(V(0, 0, 0, 0, 1, 1, 32'h300, 0), 0);
    chk("late_rv", b.redirect_valid, 1);
    chk("late_rpc", b.redirect_pc, 32'h300);
    chk("late_terr", b.timeout_err, 0);
    nop(1);
    // br_detect ignored in WAIT and REDIR
    step(V(0, 1, 1, 32'h80, 0, 0, 0, 0), 0);
    step(V(0, 1, 1, 32'h600, 1, 0, 32'h700, 0), 0);
    chk("ign_rv", b.redirect_valid, 1);
    chk("ign_rpc", b.redirect_pc, 32'h84);
    step(V(0, 1, 1, 32'h500, 0, 0, 0, 0), 0);
    nop(1);
    chk("ign_hold", b.pc_hold, 0);
    // ext_flush in WAIT and in the resolve cycle
    step(V(0, 1, 1, 32'h10, 0, 0, 0, 0), 0);
    step(V(0, 0, 0, 0, 0, 0, 0, 1), 0);
    chk("xf_wait_hold", b.pc_hold, 0);
    chk("xf_wait_rv", b.redirect_valid, 0);
    step(V(0, 1, 1, 32'h20, 0, 0, 0, 0), 0);
    step(V(0, 0, 0, 0, 1, 1, 32'h880, 1), 0);
    chk("xf_res_hold", b.pc_hold, 0);
    chk("xf_res_rv", b.redirect_valid, 0);
    nop(2);
    // reset mid-WAIT
    step(V(0, 1, 1, 32'h30, 0, 0, 0, 0), 0);
    nop(1);
    step(V(1, 0, 0, 0, 0, 0, 0, 0), 0);
    chk("rst_stall", b.stall_cnt, 0);
    chk("rst_terr", b.timeout_err, 0);
    chk("rst_rv", b.redirect_valid, 0);
    chk("rst_rpc", b.redirect_pc, 0);
    chk("rst_hold", b.pc_hold, 0);
    // saturation of the 4-bit counter
    for (int k = 0; k < 2; k++) begin
      step(V(0, 1, 1, 32'h50, 0, 0, 0, 0), 0);
      nop(MW);
    end
    step(V(0, 1, 1, 32'h50, 0, 0, 0, 0), 0);
    step(V(0, 0, 0, 0, 1, 1, 32'h90, 0), 0);
    nop(1);
    chk("sat4", b4.stall_cnt, 15);
    chk("sat16", b.stall_cnt, 20);
    step(V(0, 1, 1, 32'h50, 0, 0, 0, 0), 0);
    nop(MW);
    chk("sat4_hold", b4.stall_cnt, 15);
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pc, tgt;
      pc  = ($urandom_range(7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      tgt = $urandom;
      step(V($urandom_range(63) == 0, $urandom_range(2) == 0, $urandom_range(3) != 0, pc,
             $urandom_range(3) == 0, 1'($urandom_range(1)), tgt, $urandom_range(19) == 0), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
